// File: rtl/event_timestamp_scheduler.sv
// Stamps rising IRQ edges with a shared free-running counter and drains the
// stamped {src,ts} events round-robin into a first-word-fall-through FIFO.
module event_timestamp_scheduler #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned TS_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [NUM_SRC-1:0]            src_mask_i,
  input  logic [NUM_SRC-1:0]            irq_i,
  input  logic                          ts_clear_i,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [SRC_W-1:0]              evt_src_o,
  output logic [TS_WIDTH-1:0]           evt_ts_o,
  output logic [NUM_SRC-1:0]            pending_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [15:0]                   overflow_cnt_o,
  output logic                          busy_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {DISABLED, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic   capture;

  logic [TS_WIDTH-1:0] ts_q;
  logic [NUM_SRC-1:0]  sync1_q, sync2_q, sync3_q, edge_det, accept;
  logic [NUM_SRC-1:0]  pend_q, gnt_vec, stamp_ld, ovf_vec;
  logic [TS_WIDTH-1:0] stamp_q [NUM_SRC];
  logic [15:0]         ovf_q;
  logic [16:0]         ovf_sum;
  logic [4:0]          ovf_inc;
  logic [SRC_W-1:0]    rr_q, gnt_idx, cand;
  logic                gnt_vld, fifo_space, push, pop;
  logic [SRC_W-1:0]    mem_src [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_ts  [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [LW-1:0]       level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DISABLED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED: if (enable_i) state_d = RUN;
      RUN:      if (!enable_i) state_d = FLUSH;
      FLUSH: begin
        if (enable_i)           state_d = RUN;
        else if (pend_q == '0)  state_d = DISABLED;
      end
      default:  state_d = DISABLED;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != DISABLED);
    capture = (state_q == RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || ts_clear_i) ts_q <= '0;
    else                     ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_det   = sync2_q & ~sync3_q;
  assign accept     = edge_det & src_mask_i & {NUM_SRC{capture}};
  assign fifo_space = (level_q < LW'(FIFO_DEPTH));

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((32'(rr_q) + i) % NUM_SRC);
      if (fifo_space && !gnt_vld && pend_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // An edge landing on the grant cycle re-stamps; on a still-pending source it is dropped.
  assign gnt_vec  = gnt_vld ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign stamp_ld = accept & (~pend_q | gnt_vec);
  assign ovf_vec  = accept & pend_q & ~gnt_vec;
  assign ovf_inc  = 5'($countones(ovf_vec));
  assign ovf_sum  = {1'b0, ovf_q} + {12'b0, ovf_inc};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
    end else begin
      pend_q <= (pend_q & ~gnt_vec) | accept;
      ovf_q  <= ovf_sum[16] ? '1 : ovf_sum[15:0];
      if (gnt_vld)
        rr_q <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (rst_i)            stamp_q[s] <= '0;
      else if (stamp_ld[s]) stamp_q[s] <= ts_q;
    end
  end

  assign push = gnt_vld;
  assign pop  = evt_valid_o & evt_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_src[wr_q] <= gnt_idx;
      mem_ts[wr_q]  <= stamp_q[gnt_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign evt_valid_o    = (level_q != '0);
  assign evt_src_o      = evt_valid_o ? mem_src[rd_q] : '0;
  assign evt_ts_o       = evt_valid_o ? mem_ts[rd_q]  : '0;
  assign pending_o      = pend_q;
  assign fifo_level_o   = level_q;
  assign overflow_cnt_o = ovf_q;
endmodule

// File: tb/tb_event_timestamp_scheduler.sv
// Directed bench for event_timestamp_scheduler with a queue-based event scoreboard.
module tb_event_timestamp_scheduler;
  logic        clk = 1'b0;
  logic        rst, enable, ts_clear, ready;
  logic [3:0]  mask, irq;
  logic        valid, busy;
  logic [1:0]  src;
  logic [63:0] ts;
  logic [3:0]  pending, level;
  logic [15:0] ovf;

  logic [63:0] ts_m;
  logic [65:0] exp_q[$];
  logic [65:0] mon_e;
  logic [63:0] s_first, s9, s_a, s_b;
  int n_tests = 0;
  int n_fail  = 0;

  event_timestamp_scheduler #(
    .NUM_SRC(4), .TS_WIDTH(64), .FIFO_DEPTH(8), .SRC_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .src_mask_i(mask),
    .irq_i(irq), .ts_clear_i(ts_clear), .evt_valid_o(valid),
    .evt_ready_i(ready), .evt_src_o(src), .evt_ts_o(ts),
    .pending_o(pending), .fifo_level_o(level), .overflow_cnt_o(ovf),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT counter should hold between edges.
  always @(posedge clk) begin
    if (rst || ts_clear) ts_m <= 64'd0;
    else                 ts_m <= ts_m + 64'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input int unsigned s, input bit exp_evt);
    irq = irq | (4'b0001 << s);
    if (exp_evt) exp_q.push_back({2'(s), ts_m + 64'd2});
    tick(2);
    irq = irq & ~(4'b0001 << s);
    tick(2);
  endtask

  task automatic wait_drain(input int unsigned max_cyc);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || valid) && n < max_cyc) begin
      tick(1);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},   64'(valid),   64'd0);
    chk({tag, "_level"},   64'(level),   64'd0);
    chk({tag, "_pending"}, 64'(pending), 64'd0);
    chk({tag, "_ovf"},     64'(ovf),     64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_ts"},      ts,           64'd0);
    chk({tag, "_src"},     64'(src),     64'd0);
  endtask

  // Monitor: compares every popped head against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && valid && ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL evt_unexpected: got src=%0d ts=0x%0h, expected no event", src, ts);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_src", 64'(src), 64'(mon_e[65:64]));
          chk("evt_ts", ts, mon_e[63:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; mask = 4'hF; irq = '0; ts_clear = 1'b0; ready = 1'b0;
    tick(3);
    rst = 1'b0;
    chk_reset_state("rst");

    // T1: single event, counter cleared 10 cycles before the IRQ edge
    enable = 1'b1; ready = 1'b1;
    tick(1);
    ts_clear = 1'b1;
    tick(1);
    ts_clear = 1'b0;
    tick(9);
    irq[1] = 1'b1;
    exp_q.push_back({2'd1, 64'd11});
    tick(3);
    chk("t1_pending_k2", 64'(pending), 64'h2);
    chk("t1_valid_k2",   64'(valid),   64'd0);
    tick(1);
    chk("t1_valid_k3",   64'(valid),   64'd1);
    chk("t1_pending_k3", 64'(pending), 64'd0);
    irq[1] = 1'b0;
    wait_drain(10);

    // T2: simultaneous edges, then a second burst checking the rr pointer
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    irq = 4'b1101;
    exp_q.push_back({2'd0, ts_m + 64'd2});
    exp_q.push_back({2'd2, ts_m + 64'd2});
    exp_q.push_back({2'd3, ts_m + 64'd2});
    tick(3);
    irq = '0;
    tick(6);
    irq = 4'b1011;
    exp_q.push_back({2'd0, ts_m + 64'd2});
    exp_q.push_back({2'd1, ts_m + 64'd2});
    exp_q.push_back({2'd3, ts_m + 64'd2});
    tick(3);
    irq = '0;
    wait_drain(20);

    // T4: backpressure, 9 events from source 2 with the consumer stalled
    ready = 1'b0;
    s_first = ts_m + 64'd2;
    for (int i = 0; i < 8; i++) raise(2, 1'b1);
    irq[2] = 1'b1;
    s9 = ts_m + 64'd2;
    tick(2);
    irq[2] = 1'b0;
    tick(2);
    chk("t4_level",    64'(level),   64'd8);
    chk("t4_pending",  64'(pending), 64'h4);
    chk("t4_hold_src", 64'(src),     64'd2);
    chk("t4_hold_ts",  ts,           s_first);

    // T3: two edges on source 0 while the FIFO is full
    irq[0] = 1'b1;
    s_a = ts_m + 64'd2;
    tick(2);
    irq[0] = 1'b0;
    tick(2);
    irq[0] = 1'b1;
    tick(2);
    irq[0] = 1'b0;
    tick(3);
    chk("t3_ovf",     64'(ovf),     64'd1);
    chk("t3_pending", 64'(pending), 64'h5);
    exp_q.push_back({2'd0, s_a});
    exp_q.push_back({2'd2, s9});
    ready = 1'b1;
    wait_drain(40);
    chk("t3_ovf_after", 64'(ovf),     64'd1);
    chk("t3_level_end", 64'(level),   64'd0);
    chk("t3_pend_end",  64'(pending), 64'd0);

    // T5: flush with three pending sources and a full FIFO
    ready = 1'b0;
    for (int i = 0; i < 8; i++) raise(1, 1'b1);
    irq = 4'b1101;
    s_b = ts_m + 64'd2;
    tick(2);
    irq = '0;
    tick(3);
    chk("t5_pending", 64'(pending), 64'hD);
    exp_q.push_back({2'd2, s_b});
    exp_q.push_back({2'd3, s_b});
    exp_q.push_back({2'd0, s_b});
    enable = 1'b0;
    tick(3);
    raise(1, 1'b0);
    tick(4);
    chk("t5_busy_flush",  64'(busy),    64'd1);
    chk("t5_pend_flush",  64'(pending), 64'hD);
    chk("t5_ovf_flush",   64'(ovf),     64'd1);
    chk("t5_level_flush", 64'(level),   64'd8);
    ready = 1'b1;
    wait_drain(40);
    for (int i = 0; i < 10 && busy; i++) tick(1);
    chk("t5_busy_done", 64'(busy),    64'd0);
    chk("t5_pend_done", 64'(pending), 64'd0);

    // Edges while disabled and on a masked source are ignored
    raise(0, 1'b0);
    chk("dis_pending", 64'(pending), 64'd0);
    enable = 1'b1;
    mask = 4'b1110;
    tick(2);
    raise(0, 1'b0);
    tick(2);
    chk("mask_pending", 64'(pending), 64'd0);
    chk("mask_valid",   64'(valid),   64'd0);
    mask = 4'hF;

    // T6: counter wrap, then reset in the middle of a burst
    force dut.ts_q = 64'hFFFF_FFFF_FFFF_FFFE;
    release dut.ts_q;
    irq[3] = 1'b1;
    exp_q.push_back({2'd3, 64'd0});
    tick(2);
    irq[3] = 1'b0;
    wait_drain(20);

    ready = 1'b0;
    irq = 4'b0111;
    tick(2);
    irq = '0;
    tick(4);
    chk("t6_level_burst", 64'(level), 64'd3);
    chk("t6_valid_burst", 64'(valid), 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset_state("t6_rst");
    ready = 1'b1;
    tick(5);
    chk("t6_valid_post", 64'(valid), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
